// File: rtl/knn_pkg.sv
// Shared constants for the k-NN controller: default sizes, pipeline latencies
// and FSM state encodings.
package knn_pkg;

    localparam int DEF_NBR_TESTP = 4;
    localparam int DEF_NBR_DATAP = 4;

    localparam int unsigned MEM_LAT  = 1;
    localparam int unsigned DIST_LAT = 1;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_CLR   = 3'd1;
    localparam state_t S_RUN   = 3'd2;
    localparam state_t S_DRAIN = 3'd3;
    localparam state_t S_WRITE = 3'd4;
    localparam state_t S_DONE  = 3'd5;

endpackage

// File: rtl/knn_ctrl_pipe.sv
// Enable delay line: follows data_ren through memory and distance latency,
// tapping en_dist after the memory stage and en_list at the end.
module knn_ctrl_pipe
    import knn_pkg::*;
#(
    parameter int unsigned DEPTH    = MEM_LAT + DIST_LAT,
    parameter int unsigned DIST_TAP = MEM_LAT
)(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic data_ren,
    output logic en_dist,
    output logic en_list
);

    logic [DEPTH-1:0] line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line <= '0;
        end else if (clr) begin
            line <= '0;
        end else begin
            line[0] <= data_ren;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    assign en_dist = line[DIST_TAP-1];
    assign en_list = line[DEPTH-1];

endmodule

// File: rtl/knn_ctrl.sv
// k-NN run controller: sequences test/data memory reads, list clears/inserts and
// result writes. Define KNN_CTRL_PERF_EN to build the busy-cycle counter.
module knn_ctrl
    import knn_pkg::*;
#(
    parameter  int NBR_TESTP = DEF_NBR_TESTP,
    parameter  int NBR_DATAP = DEF_NBR_DATAP,
    localparam int TP_W      = (NBR_TESTP > 1) ? $clog2(NBR_TESTP) : 1,
    localparam int DP_W      = (NBR_DATAP > 1) ? $clog2(NBR_DATAP) : 1
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            test_ren,
    output logic [TP_W-1:0] test_addr,
    output logic            data_ren,
    output logic [DP_W-1:0] data_addr,
    output logic            en_dist,
    output logic            rst_list,
    output logic            en_list,
    output logic            res_we,
    output logic [TP_W-1:0] res_addr,
    output logic [31:0]     cycles
);

    localparam logic [TP_W-1:0] T_LAST = TP_W'(NBR_TESTP - 1);
    localparam logic [DP_W-1:0] D_LAST = DP_W'(NBR_DATAP - 1);

    state_t          state, state_n;
    logic [TP_W-1:0] t, t_n;
    logic [DP_W-1:0] d, d_n;
    logic            drain, drain_n;

    always_comb begin
        state_n = state;
        t_n     = t;
        d_n     = d;
        drain_n = drain;
        if (abort) begin
            state_n = S_IDLE;
            t_n     = '0;
            d_n     = '0;
            drain_n = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_n = S_CLR;
                        t_n     = '0;
                        d_n     = '0;
                    end
                end
                S_CLR: state_n = S_RUN;
                S_RUN: begin
                    if (d == D_LAST) begin
                        state_n = S_DRAIN;
                        drain_n = 1'b0;
                    end else begin
                        d_n = d + DP_W'(1);
                    end
                end
                // drain flags the second of the two drain cycles
                S_DRAIN: begin
                    if (drain) begin
                        state_n = S_WRITE;
                        drain_n = 1'b0;
                    end else begin
                        drain_n = 1'b1;
                    end
                end
                S_WRITE: begin
                    if (t == T_LAST) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_CLR;
                        t_n     = t + TP_W'(1);
                        d_n     = '0;
                    end
                end
                S_DONE:  state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Strobes are registered from the next-state decode so they align with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            t        <= '0;
            d        <= '0;
            drain    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            test_ren <= 1'b0;
            rst_list <= 1'b0;
            data_ren <= 1'b0;
            res_we   <= 1'b0;
        end else begin
            state    <= state_n;
            t        <= t_n;
            d        <= d_n;
            drain    <= drain_n;
            busy     <= (state_n != S_IDLE);
            done     <= (state_n == S_DONE);
            test_ren <= (state_n == S_CLR);
            rst_list <= (state_n == S_CLR);
            data_ren <= (state_n == S_RUN);
            res_we   <= (state_n == S_WRITE);
        end
    end

    assign test_addr = t;
    assign res_addr  = t;
    assign data_addr = d;

    knn_ctrl_pipe #(
        .DEPTH    (MEM_LAT + DIST_LAT),
        .DIST_TAP (MEM_LAT)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .clr      (abort),
        .data_ren (data_ren),
        .en_dist  (en_dist),
        .en_list  (en_list)
    );

`ifdef KNN_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles <= '0;
        end else if (state == S_IDLE) begin
            if (start && !abort) begin
                cycles <= '0;
            end
        end else begin
            cycles <= cycles + 32'd1;
        end
    end
`else
    assign cycles = '0;
`endif

endmodule

// File: tb/tb_knn_ctrl.sv
// Self-checking bench for knn_ctrl: a 4x4 instance and a 1x1 instance, with
// address scoreboards and a cycle-indexed strobe model.
module tb_knn_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4x4 instance
    logic        rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic        busy, done, test_ren, data_ren, en_dist, rst_list, en_list, res_we;
    logic [1:0]  test_addr, data_addr, res_addr;
    logic [31:0] cycles;

    // 1x1 instance
    logic        rst1 = 1'b1, start1 = 1'b0, abort1 = 1'b0;
    logic        busy1, done1, test_ren1, data_ren1, en_dist1, rst_list1, en_list1, res_we1;
    logic [0:0]  test_addr1, data_addr1, res_addr1;
    logic [31:0] cycles1;

    knn_ctrl #(.NBR_TESTP(4), .NBR_DATAP(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .test_ren(test_ren), .test_addr(test_addr),
        .data_ren(data_ren), .data_addr(data_addr), .en_dist(en_dist),
        .rst_list(rst_list), .en_list(en_list), .res_we(res_we),
        .res_addr(res_addr), .cycles(cycles)
    );

    knn_ctrl #(.NBR_TESTP(1), .NBR_DATAP(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .abort(abort1),
        .busy(busy1), .done(done1), .test_ren(test_ren1), .test_addr(test_addr1),
        .data_ren(data_ren1), .data_addr(data_addr1), .en_dist(en_dist1),
        .rst_list(rst_list1), .en_list(en_list1), .res_we(res_we1),
        .res_addr(res_addr1), .cycles(cycles1)
    );

    int tests = 0;
    int fails = 0;
    int res_q[$];
    int addr_q[$];
    int tst_q[$];

    // strobe vector layout: {busy, done, rst_list, test_ren, data_ren, en_dist, en_list, res_we}
    function automatic logic [7:0] exp_strobes(input int n, input int np_t, input int np_d);
        int per, k;
        logic [7:0] e;
        per = np_d + 4;
        e   = '0;
        if (n >= 1 && n <= np_t * per) begin
            k    = (n - 1) % per;
            e[7] = 1'b1;
            e[5] = (k == 0);
            e[4] = (k == 0);
            e[3] = (k >= 1 && k <= np_d);
            e[2] = (k >= 2 && k <= np_d + 1);
            e[1] = (k >= 3 && k <= np_d + 2);
            e[0] = (k == per - 1);
        end else if (n == np_t * per + 1) begin
            e[7] = 1'b1;
            e[6] = 1'b1;
        end
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start = v;
        else          start1 = v;
    endtask

    task automatic sample(input int sel, output logic [7:0] s, output int ta,
                          output int da, output int ra, output int cy);
        if (sel == 0) begin
            s  = {busy, done, rst_list, test_ren, data_ren, en_dist, en_list, res_we};
            ta = int'(test_addr);
            da = int'(data_addr);
            ra = int'(res_addr);
            cy = int'(cycles);
        end else begin
            s  = {busy1, done1, rst_list1, test_ren1, data_ren1, en_dist1, en_list1, res_we1};
            ta = int'(test_addr1);
            da = int'(data_addr1);
            ra = int'(res_addr1);
            cy = int'(cycles1);
        end
    endtask

    // One complete run from a start pulse, followed by idle cycles.
    task automatic run_check(input int sel, input int np_t, input int np_d,
                             input bit repulse, input string tag);
        int per, total, done_at, ndone, lists, seen_rst, ta, da, ra, cy, ev;
        logic [7:0] s, e;
        per = np_d + 4;
        total = np_t * per;
        res_q.delete(); addr_q.delete(); tst_q.delete();
        for (int t = 0; t < np_t; t++) begin
            res_q.push_back(t);
            tst_q.push_back(t);
            for (int d = 0; d < np_d; d++) addr_q.push_back(d);
        end
        set_start(sel, 1'b1);
        tick;
        set_start(sel, 1'b0);
        done_at = 0; ndone = 0; lists = 0; seen_rst = 0;
        for (int n = 1; n <= total + 12; n++) begin
            sample(sel, s, ta, da, ra, cy);
            e = exp_strobes(n, np_t, np_d);
            tests++;
            if (s !== e) begin
                fails++;
                $display("FAIL %s strobes cycle %0d: got %b expected %b", tag, n, s, e);
            end
            if (s[3]) begin
                tests++;
                if (addr_q.size() == 0) begin
                    fails++;
                    $display("FAIL %s data_addr cycle %0d: got read at %0d expected none", tag, n, da);
                end else begin
                    ev = addr_q.pop_front();
                    if (da !== ev) begin
                        fails++;
                        $display("FAIL %s data_addr cycle %0d: got %0d expected %0d", tag, n, da, ev);
                    end
                end
            end
            if (s[4]) begin
                tests++;
                if (tst_q.size() == 0) begin
                    fails++;
                    $display("FAIL %s test_addr cycle %0d: got read at %0d expected none", tag, n, ta);
                end else begin
                    ev = tst_q.pop_front();
                    if (ta !== ev) begin
                        fails++;
                        $display("FAIL %s test_addr cycle %0d: got %0d expected %0d", tag, n, ta, ev);
                    end
                end
            end
            if (s[0]) begin
                tests++;
                if (res_q.size() == 0) begin
                    fails++;
                    $display("FAIL %s res_addr cycle %0d: got write at %0d expected none", tag, n, ra);
                end else begin
                    ev = res_q.pop_front();
                    if (ra !== ev) begin
                        fails++;
                        $display("FAIL %s res_addr cycle %0d: got %0d expected %0d", tag, n, ra, ev);
                    end
                end
            end
            if (s[5]) begin
                if (seen_rst != 0) begin
                    tests++;
                    if (lists !== np_d) begin
                        fails++;
                        $display("FAIL %s list_inserts cycle %0d: got %0d expected %0d", tag, n, lists, np_d);
                    end
                end
                seen_rst = 1;
                lists = 0;
            end
            if (s[1]) lists++;
            if (s[6]) begin
                ndone++;
                if (done_at == 0) done_at = n;
            end
            if (repulse && (n == 3 || n == total / 2 || n == total + 1)) set_start(sel, 1'b1);
            else if (repulse) set_start(sel, 1'b0);
            tick;
        end
        set_start(sel, 1'b0);
        tests++;
        if (done_at !== total + 1) begin
            fails++;
            $display("FAIL %s done_latency: got %0d expected %0d", tag, done_at, total + 1);
        end
        tests++;
        if (ndone !== 1) begin
            fails++;
            $display("FAIL %s done_count: got %0d expected 1", tag, ndone);
        end
        tests++;
        if (lists !== np_d) begin
            fails++;
            $display("FAIL %s last_list_inserts: got %0d expected %0d", tag, lists, np_d);
        end
        tests++;
        if (res_q.size() + addr_q.size() + tst_q.size() != 0) begin
            fails++;
            $display("FAIL %s missing_accesses: got %0d left expected 0", tag,
                     res_q.size() + addr_q.size() + tst_q.size());
        end
        sample(sel, s, ta, da, ra, cy);
        tests++;
`ifdef KNN_CTRL_PERF_EN
        if (cy !== total + 1) begin
            fails++;
            $display("FAIL %s cycles: got %0d expected %0d", tag, cy, total + 1);
        end
`else
        if (cy !== 0) begin
            fails++;
            $display("FAIL %s cycles: got %0d expected 0", tag, cy);
        end
`endif
    endtask

    task automatic test_reset;
        rst = 1'b1; rst1 = 1'b1;
        tick; tick;
        tests++;
        if ({busy, done, test_ren, test_addr, data_ren, data_addr, en_dist, rst_list,
             en_list, res_we, res_addr, cycles} !== '0) begin
            fails++;
            $display("FAIL reset_4x4: got busy=%b done=%b cycles=%0d expected all zero", busy, done, cycles);
        end
        tests++;
        if ({busy1, done1, test_ren1, test_addr1, data_ren1, data_addr1, en_dist1, rst_list1,
             en_list1, res_we1, res_addr1, cycles1} !== '0) begin
            fails++;
            $display("FAIL reset_1x1: got busy=%b done=%b cycles=%0d expected all zero", busy1, done1, cycles1);
        end
        rst = 1'b0; rst1 = 1'b0;
        tick;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_full_run;
        run_check(0, 4, 4, 1'b0, "full_4x4");
    endtask

    task automatic test_min_config;
        run_check(1, 1, 1, 1'b0, "min_1x1");
    endtask

    task automatic test_abort;
        logic [7:0] s, e;
        int ta, da, ra, cy, ev, nres;
        res_q.delete();
        res_q.push_back(0);
        res_q.push_back(1);
        nres = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            sample(0, s, ta, da, ra, cy);
            e = (n <= 20) ? exp_strobes(n, 4, 4) : 8'h00;
            tests++;
            if (s !== e) begin
                fails++;
                $display("FAIL abort strobes cycle %0d: got %b expected %b", n, s, e);
            end
            if (n == 20) begin
                tests++;
                if (da !== 2 || ta !== 2) begin
                    fails++;
                    $display("FAIL abort run_point cycle 20: got t=%0d d=%0d expected t=2 d=2", ta, da);
                end
            end
            if (s[0]) begin
                nres++;
                tests++;
                if (res_q.size() == 0) begin
                    fails++;
                    $display("FAIL abort res_we cycle %0d: got write at %0d expected none", n, ra);
                end else begin
                    ev = res_q.pop_front();
                    if (ra !== ev) begin
                        fails++;
                        $display("FAIL abort res_addr cycle %0d: got %0d expected %0d", n, ra, ev);
                    end
                end
            end
            abort = (n == 20);
            tick;
        end
        abort = 1'b0;
        tests++;
        if (nres !== 2) begin
            fails++;
            $display("FAIL abort res_count: got %0d expected 2", nres);
        end
        sample(0, s, ta, da, ra, cy);
        tests++;
`ifdef KNN_CTRL_PERF_EN
        if (cy !== 20) begin
            fails++;
            $display("FAIL abort cycles_hold: got %0d expected 20", cy);
        end
`else
        if (cy !== 0) begin
            fails++;
            $display("FAIL abort cycles_hold: got %0d expected 0", cy);
        end
`endif
    endtask

    task automatic test_start_abort_idle;
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if ({busy, rst_list, test_ren, data_ren} !== 4'b0000) begin
                fails++;
                $display("FAIL start_abort_idle step %0d: got busy=%b rst_list=%b expected 0", i, busy, rst_list);
            end
            tick;
        end
    endtask

    task automatic test_reset_mid_run;
        logic [7:0] s, e;
        int ta, da, ra, cy;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            sample(0, s, ta, da, ra, cy);
            e = exp_strobes(n, 4, 4);
            tests++;
            if (s !== e) begin
                fails++;
                $display("FAIL reset_mid strobes cycle %0d: got %b expected %b", n, s, e);
            end
            if (n < 14) tick;
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({busy, done, test_ren, test_addr, data_ren, data_addr, en_dist, rst_list,
             en_list, res_we, res_addr, cycles} !== '0) begin
            fails++;
            $display("FAIL reset_mid async_clear: got busy=%b en_dist=%b en_list=%b t=%0d d=%0d expected all zero",
                     busy, en_dist, en_list, test_addr, data_addr);
        end
        tick;
        rst = 1'b0;
        tick;
        run_check(0, 4, 4, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back;
        run_check(0, 4, 4, 1'b1, "repulse");
        run_check(0, 4, 4, 1'b0, "back_to_back");
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_min_config();
        test_abort();
        test_start_abort_idle();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/knn_ctrl.md
KNN_CTRL -- requirements
Module: knn_ctrl

Interface
REQ-001 SHALL have parameter NBR_TESTP, default 4, number of test points processed per run.
REQ-002 SHALL have parameter NBR_DATAP, default 4, number of data points compared per test point.
REQ-003 SHALL derive TP_W = max(1,clog2(NBR_TESTP)) and DP_W = max(1,clog2(NBR_DATAP)) as localparams.
REQ-004 SHALL have ports, in this order:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE.
- abort  input  1  cancel current run.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of a completed run.
- test_ren  output  1  test-point memory read strobe.
- test_addr  output  TP_W  test-point index.
- data_ren  output  1  data-point memory read strobe.
- data_addr  output  DP_W  data-point index.
- en_dist  output  1  distance-datapath enable.
- rst_list  output  1  synchronous clear of the k-nearest list.
- en_list  output  1  list-insert enable.
- res_we  output  1  result-memory write strobe (list labels).
- res_addr  output  TP_W  result index.
- cycles  output  32  busy-cycle count (see Configuration).

Function
REQ-005 SHALL implement states IDLE, CLR, RUN, DRAIN, WRITE, DONE; all outputs registered.
REQ-006 IDLE: start=1 -> CLR with t=0; otherwise stay.
REQ-007 CLR (1 cycle): rst_list=1, test_ren=1, test_addr=t, d cleared to 0; -> RUN.
REQ-008 RUN (NBR_DATAP cycles): data_ren=1, data_addr=d, d increments each cycle; at d=NBR_DATAP-1 -> DRAIN.
REQ-009 en_dist SHALL equal data_ren delayed 1 cycle (memory latency); en_list SHALL equal data_ren delayed 2 cycles (memory + distance register).
REQ-010 DRAIN (exactly 2 cycles) SHALL issue no reads while the delay line empties; -> WRITE.
REQ-011 WRITE (1 cycle): res_we=1, res_addr=t; if t=NBR_TESTP-1 -> DONE, else t+1 -> CLR.
REQ-012 DONE (1 cycle): done=1, busy=1; -> IDLE.
REQ-013 Cycles per test point SHALL be NBR_DATAP+4; done SHALL assert NBR_TESTP*(NBR_DATAP+4)+1 cycles after the start-sampling edge.
REQ-014 start while busy SHALL be ignored with no queuing.
REQ-015 abort in any non-IDLE state SHALL force IDLE on the next edge, clear the delay line, suppress done and res_we; abort has priority over every transition.
REQ-016 start and abort high together in IDLE: abort wins, stay IDLE.
REQ-017 NBR_DATAP=1 and NBR_TESTP=1 SHALL work with no degenerate states skipped.
REQ-018 Counters t and d SHALL never exceed NBR_TESTP-1 / NBR_DATAP-1; no wrap-around is visible on the address outputs.

Reset
REQ-019 rst=1 SHALL immediately force IDLE, t=0, d=0, delay line 0, every output 0, including mid-run.
REQ-020 After rst deasserts, the first start SHALL be accepted normally.

Configuration
REQ-021 With KNN_CTRL_PERF_EN defined, cycles SHALL clear on accepted start, increment each busy cycle, and hold after done/abort.
REQ-022 Without KNN_CTRL_PERF_EN, cycles SHALL be constant 0 and no counter logic SHALL be generated.

Structure
REQ-023 knn_pkg SHALL hold the state enumeration, default NBR_TESTP/NBR_DATAP, and latency constants MEM_LAT=1 and DIST_LAT=1.
REQ-024 The enable delay line SHALL be a sub-module knn_ctrl_pipe (depth MEM_LAT+DIST_LAT, input data_ren, taps en_dist/en_list).

Verification
REQ-025 NBR_TESTP=4, NBR_DATAP=4, start pulse -> done exactly 33 cycles later; res_we pulses at res_addr 0,1,2,3.
REQ-026 Same run -> per test point: data_addr 0..3 on consecutive cycles; en_dist 1 cycle later, en_list 2 cycles later; 4 en_list pulses between consecutive rst_list pulses.
REQ-027 abort on the 3rd RUN cycle of test point 2 -> IDLE next cycle, busy=0, no res_we for index 2, no done.
REQ-028 rst asserted in DRAIN -> all outputs 0 with no clock edge; a new start then completes the full 33-cycle run.
REQ-029 start repulsed while busy -> ignored; exactly one done; with KNN_CTRL_PERF_EN, cycles=33 at done.
REQ-030 NBR_TESTP=1, NBR_DATAP=1 -> done 6 cycles after start; a single res_we at res_addr 0.
